iob_ptfloat2ieee_pipe: RTL and testbench

- Pipelined, parametrised converter from the internal pt-float pair (signed exponent, two's-complement mantissa) to an IEEE-754 binary word of configurable width. Covers binary32 and binary64 from one source.
- Adds run-time rounding mode selection, IEEE exception flags and a valid/ready stream interface.
- Sits at the boundary between the pt-float datapath and IEEE consumers: CPU register file, memory write-back and the testbench comparators.

---
 rtl/iob_ptfloat2ieee_pipe_if.sv | 30 +++
 rtl/iob_ptfloat2ieee_pipe.sv | 187 ++++++++++++++++++
 tb/tb_iob_ptfloat2ieee_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/iob_ptfloat2ieee_pipe_if.sv
// Stream interface for the pt-float to IEEE converter: the input side carries
// (exp, man, rnd), the output side carries the IEEE word and its flags.
interface iob_ptfloat2ieee_pipe_if #(
    parameter int EXP_W     = 10,
    parameter int MAN_W     = 24,
    parameter int FP_EXP_W  = 11,
    parameter int FP_FRAC_W = 52
);
    localparam int FP_W = 1 + FP_EXP_W + FP_FRAC_W;

    logic                    in_valid_i;
    logic                    in_ready_o;
    logic signed [EXP_W-1:0] exp_i;
    logic signed [MAN_W-1:0] man_i;
    logic [1:0]              rnd_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [FP_W-1:0]         fp_o;
    logic [3:0]              flags_o;

    modport master (
        output in_valid_i, exp_i, man_i, rnd_i, out_ready_i,
        input  in_ready_o, out_valid_o, fp_o, flags_o
    );

    modport slave (
        input  in_valid_i, exp_i, man_i, rnd_i, out_ready_i,
        output in_ready_o, out_valid_o, fp_o, flags_o
    );
endinterface

// File: rtl/iob_ptfloat2ieee_pipe.sv
// Three-stage converter from pt-float (signed exponent, two's-complement
// mantissa scaled by 2^-(MAN_W-2)) to an IEEE-754 word with run-time rounding
// mode and {overflow, underflow, inexact, zero} flags.
module iob_ptfloat2ieee_pipe #(
    parameter int EXP_W     = 10,
    parameter int MAN_W     = 24,
    parameter int FP_EXP_W  = 11,
    parameter int FP_FRAC_W = 52
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cke_i,
    iob_ptfloat2ieee_pipe_if.slave io
);
    localparam int FP_W = 1 + FP_EXP_W + FP_FRAC_W;
    localparam int BIAS = 2 ** (FP_EXP_W - 1) - 1;
    localparam int BE_W = ((EXP_W > FP_EXP_W) ? EXP_W : FP_EXP_W) + 2;
    localparam int LZ_W = $clog2(MAN_W) + 1;
    localparam int VW   = MAN_W + FP_FRAC_W + 3;

    // The MSB of the magnitude weighs 2^1, hence the extra +1 on the bias.
    localparam logic signed [BE_W-1:0] ONE    = BE_W'(1);
    localparam logic signed [BE_W-1:0] E_IN   = BE_W'(BIAS + 1);
    localparam logic signed [BE_W-1:0] SH_MAX = BE_W'(FP_FRAC_W + 2);
    localparam logic signed [BE_W-1:0] E_MAX  = BE_W'(2 ** FP_EXP_W - 1);

    localparam logic [1:0] RNE = 2'd0;
    localparam logic [1:0] RTZ = 2'd1;
    localparam logic [1:0] RUP = 2'd2;
    localparam logic [1:0] RDN = 2'd3;

    function automatic logic [LZ_W-1:0] lead_zeros(input logic [MAN_W-1:0] v);
        lead_zeros = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++)
            if (v[i]) lead_zeros = LZ_W'(MAN_W - 1 - i);
    endfunction

    function automatic logic round_inc(input logic [1:0] mode, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic r, input logic s);
        case (mode)
            RNE:     round_inc = g & (lsb | r | s);
            RTZ:     round_inc = 1'b0;
            RUP:     round_inc = ~sign & (g | r | s);
            RDN:     round_inc = sign & (g | r | s);
            default: round_inc = 1'b0;
        endcase
    endfunction

    // Overflow saturates to infinity unless rounding points back toward zero.
    function automatic logic [FP_W-1:0] ovf_word(input logic sign, input logic [1:0] mode);
        logic to_inf;
        to_inf = (mode == RNE) || (mode == RUP && !sign) || (mode == RDN && sign);
        if (to_inf) ovf_word = {sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
        else        ovf_word = {sign, {(FP_EXP_W-1){1'b1}}, 1'b0, {FP_FRAC_W{1'b1}}};
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic stall, adv;

    assign stall          = vld_p2 & ~io.out_ready_i;
    assign adv            = cke_i & ~stall;
    assign io.in_ready_o  = adv;
    assign io.out_valid_o = vld_p2;

    // Valid bits advance together; a stall freezes bubbles as well as items.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= io.in_valid_i;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- stage p0: sign, magnitude, provisional biased exponent, zero ----
    logic                   sign_p0, zero_p0;
    logic [1:0]             rnd_p0;
    logic [MAN_W-1:0]       mag_p0;
    logic signed [BE_W-1:0] be_p0;

    // Capture the input split into sign/magnitude; -2^(MAN_W-1) stays 2.0.
    always_ff @(posedge clk_i) begin
        if (adv) begin
            sign_p0 <= io.man_i[MAN_W-1];
            mag_p0  <= io.man_i[MAN_W-1] ? MAN_W'(-io.man_i) : MAN_W'(io.man_i);
            be_p0   <= BE_W'(io.exp_i) + E_IN;
            zero_p0 <= (io.man_i == '0);
            rnd_p0  <= io.rnd_i;
        end
    end

    // ---- stage p1: normalise, denormalise, guard/round/sticky ----
    logic [LZ_W-1:0]        lz;
    logic [MAN_W-1:0]       norm;
    logic signed [BE_W-1:0] be_n, sh, base;
    logic [VW-1:0]          vsh;
    logic                   tiny, g, r, s;
    logic [FP_FRAC_W:0]     kept;

    // Kept bits include the integer bit, so base is one below the final exponent.
    always_comb begin
        lz   = lead_zeros(mag_p0);
        norm = mag_p0 << lz;
        be_n = be_p0 - $signed({{(BE_W-LZ_W){1'b0}}, lz});
        tiny = be_n[BE_W-1] | (be_n == '0);
        sh   = tiny ? ONE - be_n : '0;
        base = tiny ? '0 : be_n - ONE;
        vsh  = {norm, {(FP_FRAC_W+3){1'b0}}} >> sh;
        if (sh >= SH_MAX) begin
            kept = '0;
            g    = 1'b0;
            r    = 1'b0;
            s    = |mag_p0;
        end else begin
            kept = vsh[VW-1 -: FP_FRAC_W+1];
            g    = vsh[MAN_W+1];
            r    = vsh[MAN_W];
            s    = |vsh[MAN_W-1:0];
        end
    end

    logic                   sign_p1, zero_p1, tiny_p1, g_p1, r_p1, s_p1;
    logic [1:0]             rnd_p1;
    logic [FP_FRAC_W:0]     kept_p1;
    logic signed [BE_W-1:0] base_p1;

    // Register the aligned significand and its rounding bits.
    always_ff @(posedge clk_i) begin
        if (adv) begin
            sign_p1 <= sign_p0;
            zero_p1 <= zero_p0;
            rnd_p1  <= rnd_p0;
            tiny_p1 <= tiny;
            kept_p1 <= kept;
            g_p1    <= g;
            r_p1    <= r;
            s_p1    <= s;
            base_p1 <= base;
        end
    end

    // ---- stage p2: round, exponent carry, overflow, pack ----
    logic                   inc, inexact;
    logic [FP_FRAC_W+1:0]   sum;
    logic signed [BE_W-1:0] e_fin;
    logic [FP_W-1:0]        fp_n;
    logic [3:0]             flags_n;

    // The two top bits of sum add 0, 1 or 2 to base (subnormal, normal, carry-out).
    always_comb begin
        inexact = g_p1 | r_p1 | s_p1;
        inc     = round_inc(rnd_p1, sign_p1, kept_p1[0], g_p1, r_p1, s_p1);
        sum     = {1'b0, kept_p1} + (FP_FRAC_W+2)'(inc);
        e_fin   = base_p1 + $signed({{(BE_W-2){1'b0}}, sum[FP_FRAC_W+1:FP_FRAC_W]});
        if (zero_p1) begin
            fp_n    = {sign_p1, {(FP_W-1){1'b0}}};
            flags_n = 4'b0001;
        end else if (e_fin >= E_MAX) begin
            fp_n    = ovf_word(sign_p1, rnd_p1);
            flags_n = 4'b1010;
        end else begin
            fp_n    = {sign_p1, e_fin[FP_EXP_W-1:0], sum[FP_FRAC_W-1:0]};
            flags_n = {1'b0, tiny_p1 & inexact, inexact, 1'b0};
        end
    end

    logic [FP_W-1:0] fp_p2;
    logic [3:0]      flags_p2;

    // Output word and flags; held while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fp_p2    <= '0;
            flags_p2 <= '0;
        end else if (adv) begin
            fp_p2    <= fp_n;
            flags_p2 <= flags_n;
        end
    end

    assign io.fp_o    = fp_p2;
    assign io.flags_o = flags_p2;
endmodule

// File: tb/tb_iob_ptfloat2ieee_pipe.sv
// Directed bench for iob_ptfloat2ieee_pipe: binary64, binary32 and a
// 28-bit-mantissa binary32 instance share clock and reset.
module tb_iob_ptfloat2ieee_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b1;
    int   ncmp  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    iob_ptfloat2ieee_pipe_if #(.EXP_W(10), .MAN_W(24), .FP_EXP_W(11), .FP_FRAC_W(52)) if_d ();
    iob_ptfloat2ieee_pipe_if #(.EXP_W(10), .MAN_W(24), .FP_EXP_W(8),  .FP_FRAC_W(23)) if_s ();
    iob_ptfloat2ieee_pipe_if #(.EXP_W(10), .MAN_W(28), .FP_EXP_W(8),  .FP_FRAC_W(23)) if_m ();

    iob_ptfloat2ieee_pipe #(.EXP_W(10), .MAN_W(24), .FP_EXP_W(11), .FP_FRAC_W(52)) u_d (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .io(if_d));
    iob_ptfloat2ieee_pipe #(.EXP_W(10), .MAN_W(24), .FP_EXP_W(8), .FP_FRAC_W(23)) u_s (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .io(if_s));
    iob_ptfloat2ieee_pipe #(.EXP_W(10), .MAN_W(28), .FP_EXP_W(8), .FP_FRAC_W(23)) u_m (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .io(if_m));

    logic        ov, rdy;
    logic [63:0] fpv;
    logic [3:0]  flv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int cfg);
        case (cfg)
            0: begin ov = if_d.out_valid_o; rdy = if_d.in_ready_o; fpv = if_d.fp_o;          flv = if_d.flags_o; end
            1: begin ov = if_s.out_valid_o; rdy = if_s.in_ready_o; fpv = {32'h0, if_s.fp_o}; flv = if_s.flags_o; end
            default: begin ov = if_m.out_valid_o; rdy = if_m.in_ready_o; fpv = {32'h0, if_m.fp_o}; flv = if_m.flags_o; end
        endcase
    endtask

    task automatic idle_all();
        if_d.in_valid_i = 1'b0; if_s.in_valid_i = 1'b0; if_m.in_valid_i = 1'b0;
    endtask

    // Starts and ends just after a rising edge; one item, latency and value checks.
    task automatic run1(input string tag, input int cfg, input logic [9:0] e,
                        input logic [27:0] m, input logic [1:0] r,
                        input logic [63:0] xfp, input logic [3:0] xfl);
        case (cfg)
            0: begin if_d.in_valid_i = 1'b1; if_d.exp_i = e; if_d.man_i = m[23:0]; if_d.rnd_i = r; end
            1: begin if_s.in_valid_i = 1'b1; if_s.exp_i = e; if_s.man_i = m[23:0]; if_s.rnd_i = r; end
            default: begin if_m.in_valid_i = 1'b1; if_m.exp_i = e; if_m.man_i = m; if_m.rnd_i = r; end
        endcase
        @(negedge clk); sample(cfg);
        chk({tag, "_in_ready"}, 64'(rdy), 64'd1);
        @(posedge clk); #1 idle_all();
        @(posedge clk);
        @(negedge clk); sample(cfg);
        chk({tag, "_early_valid"}, 64'(ov), 64'd0);
        @(posedge clk);
        @(negedge clk); sample(cfg);
        chk({tag, "_valid"}, 64'(ov), 64'd1);
        chk({tag, "_fp"}, fpv, xfp);
        chk({tag, "_flags"}, 64'(flv), 64'(xfl));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv;
        idle_all();
        if_d.out_ready_i = 1'b1; if_s.out_ready_i = 1'b1; if_m.out_ready_i = 1'b1;
        if_d.exp_i = '0; if_d.man_i = '0; if_d.rnd_i = '0;
        if_s.exp_i = '0; if_s.man_i = '0; if_s.rnd_i = '0;
        if_m.exp_i = '0; if_m.man_i = '0; if_m.rnd_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk); sample(0);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_fp", fpv, 64'd0);
        chk("rst_flags", 64'(flv), 64'd0);
        chk("rst_in_ready", 64'(rdy), 64'd1);
        @(posedge clk); #1;

        run1("one",      0, 10'd0,   28'h0400000, 2'd0, 64'h3FF0000000000000, 4'b0000);
        run1("neg_one",  0, 10'd0,   28'h0C00000, 2'd0, 64'hBFF0000000000000, 4'b0000);
        run1("zero",     0, 10'h200, 28'h0000000, 2'd0, 64'h0000000000000000, 4'b0001);
        run1("neg_two",  0, 10'd0,   28'h0800000, 2'd0, 64'hC000000000000000, 4'b0000);
        run1("ovf_rne",  1, 10'd200, 28'h0400000, 2'd0, 64'h7F800000, 4'b1010);
        run1("ovf_rtz",  1, 10'd200, 28'h0400000, 2'd1, 64'h7F7FFFFF, 4'b1010);
        run1("ovf_rdnp", 1, 10'd200, 28'h0400000, 2'd3, 64'h7F7FFFFF, 4'b1010);
        run1("ovf_rdnn", 1, 10'd200, 28'h0C00000, 2'd3, 64'hFF800000, 4'b1010);
        run1("sub_exact",1, 10'h37E, 28'h0400000, 2'd0, 64'h00080000, 4'b0000);
        run1("sub_rne",  1, 10'h360, 28'h0400000, 2'd0, 64'h00000000, 4'b0110);
        run1("sub_rup",  1, 10'h360, 28'h0400000, 2'd2, 64'h00000001, 4'b0110);
        run1("tie_rne",  2, 10'd0,   28'h4000004, 2'd0, 64'h3F800000, 4'b0010);
        run1("tie_rup",  2, 10'd0,   28'h4000004, 2'd2, 64'h3F800001, 4'b0010);
        run1("odd_rne",  2, 10'd0,   28'h400000C, 2'd0, 64'h3F800002, 4'b0010);
        run1("sub2norm", 2, 10'h381, 28'h7FFFFFF, 2'd0, 64'h00800000, 4'b0110);
        run1("sub_rtz",  2, 10'h381, 28'h7FFFFFF, 2'd1, 64'h007FFFFF, 4'b0110);

        cke = 1'b0;
        @(negedge clk); sample(0);
        chk("cke_in_ready", 64'(rdy), 64'd0);
        @(posedge clk); #1 cke = 1'b1;

        // 8 back-to-back items, consumer stalls in cycles 4..7.
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if_d.in_valid_i  = (sent < 8);
            if_d.exp_i       = 10'(sent);
            if_d.man_i       = 24'h400000;
            if_d.rnd_i       = 2'd0;
            if_d.out_ready_i = !(cyc >= 4 && cyc <= 7);
            @(negedge clk);
            if (cyc < 12) chk("stream_in_ready", 64'(if_d.in_ready_o), 64'(!(cyc >= 4 && cyc <= 7)));
            if (cyc >= 4 && cyc <= 7) begin
                chk("stall_valid", 64'(if_d.out_valid_o), 64'd1);
                chk("stall_hold", if_d.fp_o, {1'b0, 11'(1023 + recv), 52'h0});
            end
            if (if_d.in_valid_i && if_d.in_ready_o) sent++;
            if (if_d.out_valid_o && if_d.out_ready_i) begin
                chk("stream_extra", 64'(recv < 8), 64'd1);
                chk("stream_fp", if_d.fp_o, {1'b0, 11'(1023 + recv), 52'h0});
                recv++;
            end
            @(posedge clk); #1;
        end
        if_d.in_valid_i  = 1'b0;
        if_d.out_ready_i = 1'b1;
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_recv", 64'(recv), 64'd8);

        // Reset asserted in cycle 2 of a burst: nothing may come out.
        for (int cyc = 0; cyc < 10; cyc++) begin
            if_d.in_valid_i = (cyc < 3);
            if_d.exp_i      = 10'(cyc);
            if_d.man_i      = 24'h400000;
            rst             = (cyc == 2);
            @(negedge clk);
            if (cyc >= 3) chk("rst_burst_valid", 64'(if_d.out_valid_o), 64'd0);
            @(posedge clk); #1;
        end
        if_d.in_valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
